// File: rtl/accumulator_ctrl_pkg.sv
// Shared encodings for the accumulator CPU control path: FSM states, opcodes,
// datapath select codes and the control-word payload driven to the datapath.
package accumulator_ctrl_pkg;

  localparam int unsigned StateW  = 4;
  localparam int unsigned OpcodeW = 4;

  typedef enum logic [StateW-1:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecImm = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StSpInc   = 4'd5,
    StSpDec   = 4'd6,
    StMemWr   = 4'd7,
    StBranch  = 4'd8,
    StHalted  = 4'd9
  } stateT;

  localparam logic [OpcodeW-1:0] OpHalt  = 4'h0;
  localparam logic [OpcodeW-1:0] OpLui   = 4'h1;
  localparam logic [OpcodeW-1:0] OpLi    = 4'h2;
  localparam logic [OpcodeW-1:0] OpAddi  = 4'h3;
  localparam logic [OpcodeW-1:0] OpLoad  = 4'h4;
  localparam logic [OpcodeW-1:0] OpStore = 4'h5;
  localparam logic [OpcodeW-1:0] OpPush  = 4'h6;
  localparam logic [OpcodeW-1:0] OpPop   = 4'h7;
  localparam logic [OpcodeW-1:0] OpBeqz  = 4'h8;
  localparam logic [OpcodeW-1:0] OpAdd   = 4'h9;
  localparam logic [OpcodeW-1:0] OpSub   = 4'hA;
  localparam logic [OpcodeW-1:0] OpAnd   = 4'hB;
  localparam logic [OpcodeW-1:0] OpOr    = 4'hC;

  localparam logic [2:0] AccSrcIrHi    = 3'd0;
  localparam logic [2:0] AccSrcMdr     = 3'd1;
  localparam logic [2:0] AccSrcMemData = 3'd2;
  localparam logic [2:0] AccSrcSe      = 3'd3;
  localparam logic [2:0] AccSrcAlu     = 3'd4;

  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluSub = 3'd1;
  localparam logic [2:0] AluAnd = 3'd2;
  localparam logic [2:0] AluOr  = 3'd3;

  localparam logic [1:0] AddrPc = 2'd0;
  localparam logic [1:0] AddrZe = 2'd1;
  localparam logic [1:0] AddrSp = 2'd2;

  localparam logic [1:0] SrcAPc  = 2'd0;
  localparam logic [1:0] SrcAAcc = 2'd1;
  localparam logic [1:0] SrcASp  = 2'd2;

  localparam logic [1:0] SrcBMdr    = 2'd0;
  localparam logic [1:0] SrcBTwo    = 2'd1;
  localparam logic [1:0] SrcBSe     = 2'd2;
  localparam logic [1:0] SrcBSeLeft = 2'd3;

  typedef struct packed {
    logic [2:0] accSrc;
    logic       accWrite;
    logic       spWrite;
    logic       pcWrite;
    logic       irWrite;
    logic       mdrWrite;
    logic       memRead;
    logic       memWrite;
    logic [1:0] iorD;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
  } ctrlT;

endpackage

// File: rtl/accumulator_control_if.sv
// Control bus between the accumulator control FSM (master) and the datapath (slave).
// The Illegal flag exists only when ACC_ILLEGAL_TRAP_EN is defined.
interface accumulator_control_if;
  import accumulator_ctrl_pkg::*;

  logic [OpcodeW-1:0] Opcode;
  logic               AccZero;
  logic               MemReady;
  logic [2:0]         AccSrc;
  logic               AccWrite;
  logic               SpWrite;
  logic               PCWrite;
  logic               IRWrite;
  logic               MDRWrite;
  logic               MemRead;
  logic               MemWrite;
  logic [1:0]         IorD;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [2:0]         ALUOp;
  logic               Halted;
  logic               MemError;
`ifdef ACC_ILLEGAL_TRAP_EN
  logic               Illegal;
`endif

  modport master (
`ifdef ACC_ILLEGAL_TRAP_EN
    output Illegal,
`endif
    input  Opcode, AccZero, MemReady,
    output AccSrc, AccWrite, SpWrite, PCWrite, IRWrite, MDRWrite,
           MemRead, MemWrite, IorD, ALUSrcA, ALUSrcB, ALUOp, Halted, MemError
  );

  modport slave (
`ifdef ACC_ILLEGAL_TRAP_EN
    input  Illegal,
`endif
    output Opcode, AccZero, MemReady,
    input  AccSrc, AccWrite, SpWrite, PCWrite, IRWrite, MDRWrite,
           MemRead, MemWrite, IorD, ALUSrcA, ALUSrcB, ALUOp, Halted, MemError
  );

endinterface

// File: rtl/accumulator_control_mem_wait_timer.sv
// Memory-wait stall counter: expired pulses on the WAIT_LIMIT-th consecutive stall
// cycle since the last clr. WAIT_LIMIT of 0 disables the timeout entirely.
module mem_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic CLK,
  input  logic reset,
  input  logic clr,
  input  logic count,
  output logic expired
);

  generate
    if (WAIT_LIMIT == 0) begin : gNever
      logic unusedInputs;
      assign unusedInputs = clr | count | CLK | reset;
      assign expired = 1'b0;
    end else begin : gCount
      localparam int unsigned CntW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
      logic [CntW-1:0] cnt;

      assign expired = count && (cnt == CntW'(WAIT_LIMIT - 1));

      // clr wins so every freshly entered wait state starts from zero
      always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
          cnt <= '0;
        end else if (clr) begin
          cnt <= '0;
        end else if (count && !expired) begin
          cnt <= cnt + CntW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/accumulator_control.sv
// Multicycle control FSM for the accumulator CPU (fetch/decode/execute/memory handshakes).
// Define ACC_ILLEGAL_TRAP_EN to trap opcodes D-F into HALTED with a sticky Illegal flag.
module accumulator_control
  import accumulator_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic                 CLK,
  input  logic                 reset,
  accumulator_control_if.master bus
);

  stateT state, stateNext;
  ctrlT  ctl, ctlOut;
  logic  waitState, memStall, stateChange, expired, memError;

  assign waitState   = (state == StFetch) || (state == StMemRd) || (state == StMemWr);
  assign memStall    = waitState && !bus.MemReady;
  assign stateChange = (stateNext != state);

  mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) uWaitTimer (
    .CLK     (CLK),
    .reset   (reset),
    .clr     (stateChange),
    .count   (memStall),
    .expired (expired)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= StFetch;
    else        state <= stateNext;
  end

  // Next state and Moore control word; handshake strobes qualify on MemReady
  always_comb begin
    stateNext = state;
    ctl       = '0;
    unique case (state)
      StFetch: begin
        ctl.memRead = 1'b1;
        ctl.iorD    = AddrPc;
        if (bus.MemReady) begin
          ctl.irWrite = 1'b1;
          ctl.pcWrite = 1'b1;
          ctl.aluSrcA = SrcAPc;
          ctl.aluSrcB = SrcBTwo;
          ctl.aluOp   = AluAdd;
          stateNext   = StDecode;
        end
      end
      StDecode: begin
        case (bus.Opcode)
          OpHalt:                       stateNext = StHalted;
          OpLui, OpLi, OpAddi:          stateNext = StExecImm;
          OpLoad, OpAdd, OpSub, OpAnd,
          OpOr, OpPop:                  stateNext = StMemRd;
          OpStore:                      stateNext = StMemWr;
          OpPush:                       stateNext = StSpDec;
          OpBeqz:                       stateNext = StBranch;
`ifdef ACC_ILLEGAL_TRAP_EN
          default:                      stateNext = StHalted;
`else
          default:                      stateNext = StFetch;
`endif
        endcase
      end
      StExecImm: begin
        ctl.accWrite = 1'b1;
        case (bus.Opcode)
          OpLi:    ctl.accSrc = AccSrcSe;
          OpAddi: begin
            ctl.accSrc  = AccSrcAlu;
            ctl.aluSrcA = SrcAAcc;
            ctl.aluSrcB = SrcBSe;
            ctl.aluOp   = AluAdd;
          end
          default: ctl.accSrc = AccSrcIrHi;
        endcase
        stateNext = StFetch;
      end
      StMemRd: begin
        ctl.memRead = 1'b1;
        ctl.iorD    = (bus.Opcode == OpPop) ? AddrSp : AddrZe;
        if (bus.MemReady) begin
          ctl.mdrWrite = 1'b1;
          stateNext    = StMemWb;
        end
      end
      StMemWb: begin
        ctl.accWrite = 1'b1;
        case (bus.Opcode)
          OpAdd, OpSub, OpAnd, OpOr: begin
            ctl.accSrc  = AccSrcAlu;
            ctl.aluSrcA = SrcAAcc;
            ctl.aluSrcB = SrcBMdr;
            ctl.aluOp   = (bus.Opcode == OpSub) ? AluSub :
                          (bus.Opcode == OpAnd) ? AluAnd :
                          (bus.Opcode == OpOr)  ? AluOr  : AluAdd;
          end
          default: ctl.accSrc = AccSrcMdr;
        endcase
        stateNext = (bus.Opcode == OpPop) ? StSpInc : StFetch;
      end
      StSpInc: begin
        ctl.spWrite = 1'b1;
        ctl.aluSrcA = SrcASp;
        ctl.aluSrcB = SrcBTwo;
        ctl.aluOp   = AluAdd;
        stateNext   = StFetch;
      end
      StSpDec: begin
        ctl.spWrite = 1'b1;
        ctl.aluSrcA = SrcASp;
        ctl.aluSrcB = SrcBTwo;
        ctl.aluOp   = AluSub;
        stateNext   = StMemWr;
      end
      StMemWr: begin
        ctl.memWrite = 1'b1;
        ctl.iorD     = (bus.Opcode == OpPush) ? AddrSp : AddrZe;
        if (bus.MemReady) stateNext = StFetch;
      end
      StBranch: begin
        if (bus.AccZero) begin
          ctl.pcWrite = 1'b1;
          ctl.aluSrcA = SrcAPc;
          ctl.aluSrcB = SrcBSeLeft;
          ctl.aluOp   = AluAdd;
        end
        stateNext = StFetch;
      end
      StHalted: stateNext = StHalted;
      default:  stateNext = StFetch;
    endcase
    if (expired) stateNext = StHalted;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)       memError <= 1'b0;
    else if (expired) memError <= 1'b1;
  end

`ifdef ACC_ILLEGAL_TRAP_EN
  logic illegal;
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)                                           illegal <= 1'b0;
    else if ((state == StDecode) && (bus.Opcode > OpOr)) illegal <= 1'b1;
  end
  assign bus.Illegal = illegal;
`endif

  // Nothing reaches the datapath while reset is held, even mid-handshake
  assign ctlOut = reset ? ctl : '0;

  assign bus.AccSrc   = ctlOut.accSrc;
  assign bus.AccWrite = ctlOut.accWrite;
  assign bus.SpWrite  = ctlOut.spWrite;
  assign bus.PCWrite  = ctlOut.pcWrite;
  assign bus.IRWrite  = ctlOut.irWrite;
  assign bus.MDRWrite = ctlOut.mdrWrite;
  assign bus.MemRead  = ctlOut.memRead;
  assign bus.MemWrite = ctlOut.memWrite;
  assign bus.IorD     = ctlOut.iorD;
  assign bus.ALUSrcA  = ctlOut.aluSrcA;
  assign bus.ALUSrcB  = ctlOut.aluSrcB;
  assign bus.ALUOp    = ctlOut.aluOp;
  assign bus.Halted   = (state == StHalted);
  assign bus.MemError = memError;

endmodule
